// File: rtl/local_port_responder.sv
// Target-side responder for 68040 _TS-started, DSACK-terminated local bus cycles.
// Drives byte lanes and a timed peripheral strobe, then terminates with DSACK or _BERR.
module local_port_responder #(
  parameter int PORT32      = 0,
  parameter int WAIT_STATES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic       BCLK,
  input  logic       nRESET,
  input  logic       nTS,
  input  logic       nCS,
  input  logic       RnW,
  input  logic [1:0] SIZ,
  input  logic [1:0] A,
  input  logic       nRDY,
  output logic [1:0] DSACK,
  output logic       nBERR,
  output logic [3:0] nBE,
  output logic       nSTB,
  output logic       PRnW,
  output logic       nDOE,
  output logic       nWOE
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    ACK,
    BERR,
    RECOVER
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] ACK_CODE  = (PORT32 != 0) ? 2'b00 : 2'b01;

  state_t     state, state_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       rnw_q, rnw_n;
  logic [3:0] lanes_q, lanes_n;

  logic [1:0] dsack_n;
  logic       nberr_n, nstb_n, prnw_n, ndoe_n, nwoe_n;
  logic [3:0] nbe_n;

  // Active-low lane enables; bit 0 is the most significant byte lane.
  function automatic logic [3:0] lane_map(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] lanes;
    lanes = '1;
    if (PORT32 != 0) begin
      case (siz)
        2'b00, 2'b11: lanes = '0;
        2'b10: begin
          if (a == 2'b00)      lanes = 4'b1100;
          else if (a == 2'b10) lanes = 4'b0011;
          else                 lanes = ~(4'b0001 << a);
        end
        default: lanes = ~(4'b0001 << a);
      endcase
    end else begin
      if (siz == 2'b01) lanes = a[0] ? 4'b1101 : 4'b1110;
      else              lanes = 4'b1100;
    end
    return lanes;
  endfunction

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    tmo_cnt_n  = tmo_cnt;
    rnw_n      = rnw_q;
    lanes_n    = lanes_q;
    case (state)
      IDLE: begin
        if (!nTS && !nCS) begin
          rnw_n   = RnW;
          lanes_n = lane_map(SIZ, A);
          state_n = SETUP;
        end
      end
      SETUP: begin
        wait_cnt_n = WAIT_LOAD;
        tmo_cnt_n  = '0;
        state_n    = STROBE;
      end
      STROBE: begin
        tmo_cnt_n = tmo_cnt + 8'd1;
        if (wait_cnt != '0)       wait_cnt_n = wait_cnt - 4'd1;
        else if (!nRDY)           state_n = ACK;
        else if (tmo_cnt == TMO_LAST) state_n = BERR;
      end
      ACK, BERR: state_n = RECOVER;
      default:   state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that every pin comes straight from a flop.
  always_comb begin
    dsack_n = 2'b11;
    nberr_n = 1'b1;
    nbe_n   = '1;
    nstb_n  = 1'b1;
    prnw_n  = 1'b1;
    ndoe_n  = 1'b1;
    nwoe_n  = 1'b1;
    if (state_n inside {SETUP, STROBE, ACK, BERR}) begin
      nbe_n  = lanes_n;
      prnw_n = rnw_n;
      nwoe_n = rnw_n;
    end
    if (state_n inside {STROBE, ACK, BERR}) begin
      nstb_n = 1'b0;
      ndoe_n = ~rnw_n;
    end
    if (state_n == ACK)  dsack_n = ACK_CODE;
    if (state_n == BERR) nberr_n = 1'b0;
  end

  always_ff @(posedge BCLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
      rnw_q    <= 1'b1;
      lanes_q  <= '1;
      DSACK    <= 2'b11;
      nBERR    <= 1'b1;
      nBE      <= '1;
      nSTB     <= 1'b1;
      PRnW     <= 1'b1;
      nDOE     <= 1'b1;
      nWOE     <= 1'b1;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      tmo_cnt  <= tmo_cnt_n;
      rnw_q    <= rnw_n;
      lanes_q  <= lanes_n;
      DSACK    <= dsack_n;
      nBERR    <= nberr_n;
      nBE      <= nbe_n;
      nSTB     <= nstb_n;
      PRnW     <= prnw_n;
      nDOE     <= ndoe_n;
      nWOE     <= nwoe_n;
    end
  end

endmodule
